// File: rtl/fifo_pkg.sv
// Shared helpers for the peek FIFO family: count-bus sizing and a min/clamp helper.
package fifo_pkg;

  // Width of a count bus able to hold 0..2**depth_bits inclusive.
  function automatic int FIFO_CNT_W(input int depth_bits);
    return depth_bits + 1;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the peek FIFO: synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int DEPTH_BITS = 4,
  parameter int WIDTH      = 6
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [1 << DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/peek_fifo.sv
// Peek FIFO with multi-entry pop, occupancy count, almost-full, sticky error
// flags, synchronous flush and a peek output masked to zero beyond valid data.
module peek_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH_BITS  = 4,
  parameter int WIDTH       = 6,
  parameter int POP_BITS    = 2,
  parameter int AFULL_LEVEL = (1 << DEPTH_BITS) - 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    write_en,
  input  logic [WIDTH-1:0]        data_in,
  input  logic [POP_BITS-1:0]     pop_n,
  input  logic [DEPTH_BITS-1:0]   peek,
  output logic [WIDTH-1:0]        data_out,
  output logic                    peek_valid,
  output logic [DEPTH_BITS:0]     count,
  output logic                    empty_n,
  output logic                    full_n,
  output logic                    almost_full,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clear_err
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = FIFO_CNT_W(DEPTH_BITS);
  localparam int XW    = DEPTH_BITS + 2;

  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [XW-1:0]         popped, remain, count_next;
  logic                  underflow_req, accept, mem_wr_en;
  logic [DEPTH_BITS-1:0] rd_addr;
  logic [WIDTH-1:0]      rd_data;

  always_comb begin
    popped        = XW'(min_u(32'(pop_n), 32'(count_q)));
    underflow_req = XW'(pop_n) > XW'(count_q);
    remain        = XW'(count_q) - popped;
    // A same-cycle pop frees space, so a write into a full FIFO can still land.
    accept        = write_en && (remain < XW'(DEPTH));
    count_next    = remain + XW'(accept);
    mem_wr_en     = accept && !flush;

    rd_ptr_d    = rd_ptr_q + popped[DEPTH_BITS-1:0];
    wr_ptr_d    = wr_ptr_q + DEPTH_BITS'(accept);
    count_d     = count_next[CW-1:0];
    overflow_d  = (overflow_q && !clear_err) || (write_en && !accept && !flush);
    underflow_d = (underflow_q && !clear_err) || (underflow_req && !flush);

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DEPTH_BITS (DEPTH_BITS),
    .WIDTH      (WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_addr     = rd_ptr_q + peek;
  // Stale storage beyond the occupancy must never leak to the consumer.
  assign peek_valid  = CW'(peek) < count_q;
  assign data_out    = peek_valid ? rd_data : '0;
  assign count       = count_q;
  assign empty_n     = (count_q != '0);
  assign full_n      = (count_q != CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AFULL_LEVEL));
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_peek_fifo.sv
// Directed self-checking bench for peek_fifo with hand-computed expectations.
module tb_peek_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush, write_en, clear_err;
  logic [5:0] data_in;
  logic [1:0] pop_n;
  logic [3:0] peek;
  logic [5:0] data_out;
  logic       peek_valid;
  logic [4:0] count;
  logic       empty_n, full_n, almost_full, overflow, underflow;

  int vectors = 0;
  int miscompares = 0;

  peek_fifo dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .write_en    (write_en),
    .data_in     (data_in),
    .pop_n       (pop_n),
    .peek        (peek),
    .data_out    (data_out),
    .peek_valid  (peek_valid),
    .count       (count),
    .empty_n     (empty_n),
    .full_n      (full_n),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow),
    .clear_err   (clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later, idle inputs.
  task automatic cyc(input logic we, input logic [5:0] d, input logic [1:0] p,
                     input logic fl, input logic ce);
    write_en  = we;
    data_in   = d;
    pop_n     = p;
    flush     = fl;
    clear_err = ce;
    @(posedge clk);
    #1;
    write_en  = 1'b0;
    data_in   = '0;
    pop_n     = '0;
    flush     = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic peek_chk(input string tag, input logic [3:0] p, input logic [5:0] exp);
    peek = p;
    #1;
    chk(tag, 32'(data_out), 32'(exp));
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0; write_en = 1'b0; clear_err = 1'b0;
    data_in = '0; pop_n = '0; peek = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty_n", 32'(empty_n), 32'd0);
    chk("rst_full_n", 32'(full_n), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_pvalid", 32'(peek_valid), 32'd0);
    reset_n = 1'b1;

    // Reset asserted between edges must act immediately.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 6'(i), 2'd0, 1'b0, 1'b0);
    chk("mid_count5", 32'(count), 32'd5);
    chk("mid_head", 32'(data_out), 32'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty_n", 32'(empty_n), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to 16; almost_full must rise exactly when count reaches 14.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 6'(i), 2'd0, 1'b0, 1'b0);
      chk($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
      chk($sformatf("fill_afull_%0d", i), 32'(almost_full), 32'(i >= 14));
    end
    chk("full_full_n", 32'(full_n), 32'd0);
    chk("full_ovf_pre", 32'(overflow), 32'd0);
    cyc(1'b1, 6'h3F, 2'd0, 1'b0, 1'b0);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    peek_chk("ovf_peek15", 4'd15, 6'h10);
    cyc(1'b1, 6'h11, 2'd1, 1'b0, 1'b0);
    chk("wpop_count", 32'(count), 32'd16);
    peek_chk("wpop_head", 4'd0, 6'h02);
    peek_chk("wpop_peek15", 4'd15, 6'h11);
    cyc(1'b0, 6'h00, 2'd3, 1'b0, 1'b0);
    chk("afull_drop_count", 32'(count), 32'd13);
    chk("afull_drop", 32'(almost_full), 32'd0);
    peek_chk("afull_drop_head", 4'd0, 6'h05);
    cyc(1'b0, 6'h00, 2'd0, 1'b1, 1'b0);
    chk("flush1_count", 32'(count), 32'd0);
    chk("flush1_ovf_kept", 32'(overflow), 32'd1);

    // Exact pop of all entries is not an underflow; popping an empty FIFO is.
    cyc(1'b1, 6'h0A, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 6'h0B, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 6'h0C, 2'd0, 1'b0, 1'b0);
    peek_chk("abc_peek2", 4'd2, 6'h0C);
    cyc(1'b0, 6'h00, 2'd3, 1'b0, 1'b0);
    chk("pop3_count", 32'(count), 32'd0);
    chk("pop3_unf", 32'(underflow), 32'd0);
    cyc(1'b0, 6'h00, 2'd2, 1'b0, 1'b0);
    chk("pop_empty_count", 32'(count), 32'd0);
    chk("pop_empty_unf", 32'(underflow), 32'd1);

    // Wrap-around: head pointer at 3 now; write 12, pop 10, write 10.
    for (int i = 0; i < 12; i++) cyc(1'b1, 6'(8'h20 + i), 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 2'd3, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 2'd3, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 2'd3, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 2'd1, 1'b0, 1'b0);
    chk("wrap_count2", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) cyc(1'b1, 6'(8'h30 + i), 2'd0, 1'b0, 1'b0);
    chk("wrap_count12", 32'(count), 32'd12);
    for (int i = 0; i < 12; i++)
      peek_chk($sformatf("wrap_peek%0d", i), 4'(i),
               (i < 2) ? 6'(8'h2A + i) : 6'(8'h30 + i - 2));
    peek_chk("wrap_peek12", 4'd12, 6'h00);
    chk("wrap_pvalid12", 32'(peek_valid), 32'd0);
    peek = 4'd0;

    // Flush at count 7 with simultaneous write and pop; flags untouched.
    cyc(1'b0, 6'h00, 2'd3, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 2'd2, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd7);
    cyc(1'b1, 6'h15, 2'd2, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty_n", 32'(empty_n), 32'd0);
    chk("flush_ovf", 32'(overflow), 32'd1);
    chk("flush_unf", 32'(underflow), 32'd1);
    cyc(1'b0, 6'h00, 2'd0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_unf", 32'(underflow), 32'd0);

    // A new error in the same cycle as clear_err keeps the flag set.
    cyc(1'b0, 6'h00, 2'd1, 1'b0, 1'b0);
    chk("unf_again", 32'(underflow), 32'd1);
    cyc(1'b0, 6'h00, 2'd1, 1'b0, 1'b1);
    chk("set_wins_unf", 32'(underflow), 32'd1);
    chk("set_wins_ovf", 32'(overflow), 32'd0);
    cyc(1'b0, 6'h00, 2'd0, 1'b0, 1'b1);
    chk("final_clr_unf", 32'(underflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
